// File: rtl/ram_port_arbiter.sv
// Two-port frame arbiter in front of a single-port RAM: locks the grant to one
// requester for a whole address/data transaction and steers read data back to it.
module ram_port_arbiter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] a_frame,
  input  logic       a_valid,
  output logic       a_ready,
  output logic [7:0] a_rdata,
  output logic       a_rvalid,
  input  logic [9:0] b_frame,
  input  logic       b_valid,
  output logic       b_ready,
  output logic [7:0] b_rdata,
  output logic       b_rvalid,
  output logic [9:0] ram_din,
  output logic       ram_rx_valid,
  input  logic [7:0] ram_dout,
  input  logic       ram_tx_valid,
  output logic [1:0] owner,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE, OWN_WR, OWN_RD, WAIT_RD} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_A    = 2'b01;
  localparam logic [1:0] OWN_B    = 2'b10;

  state_t               state, state_next;
  logic [1:0]           owner_next;
  logic                 prio, prio_next;  // 0 = A has priority, 1 = B
  logic [CNT_WIDTH-1:0] cnt, cnt_next;
  logic                 timeout_next;
  logic                 grant_a, grant_b, hs_a, hs_b, hs, expire;
  logic [9:0]           frame_sel;
  logic [1:0]           cmd;
  logic [1:0]           hs_owner;

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    case (state)
      IDLE: begin
        if (a_valid && (!b_valid || !prio)) grant_a = 1'b1;
        else if (b_valid)                   grant_b = 1'b1;
      end
      OWN_WR, OWN_RD: begin
        grant_a = (owner == OWN_A);
        grant_b = (owner == OWN_B);
      end
      default: ;
    endcase
  end

  assign a_ready   = grant_a;
  assign b_ready   = grant_b;
  assign hs_a      = a_valid && grant_a;
  assign hs_b      = b_valid && grant_b;
  assign hs        = hs_a || hs_b;
  assign frame_sel = hs_b ? b_frame : a_frame;
  assign cmd       = frame_sel[9:8];
  assign hs_owner  = hs_b ? OWN_B : OWN_A;

  // A returning read beats the timer when both land on the same edge.
  assign expire = (state != IDLE) && !hs && (cnt == CNT_LAST) &&
                  !(state == WAIT_RD && ram_tx_valid);

  always_comb begin
    state_next   = state;
    owner_next   = owner;
    prio_next    = prio;
    timeout_next = 1'b0;
    case (state)
      IDLE: begin
        if (hs) begin
          case (cmd)
            2'b00: begin state_next = OWN_WR;  owner_next = hs_owner; end
            2'b10: begin state_next = OWN_RD;  owner_next = hs_owner; end
            2'b11: begin state_next = WAIT_RD; owner_next = hs_owner; end
            default: prio_next = !hs_b;
          endcase
        end
      end
      OWN_WR, OWN_RD: begin
        if (hs) begin
          case (cmd)
            2'b00: state_next = OWN_WR;
            2'b10: state_next = OWN_RD;
            2'b11: state_next = WAIT_RD;
            default: begin
              state_next = IDLE;
              owner_next = OWN_NONE;
              prio_next  = (owner == OWN_A);
            end
          endcase
        end else if (expire) begin
          state_next   = IDLE;
          owner_next   = OWN_NONE;
          prio_next    = (owner == OWN_A);
          timeout_next = 1'b1;
        end
      end
      default: begin
        if (ram_tx_valid || expire) begin
          state_next   = IDLE;
          owner_next   = OWN_NONE;
          prio_next    = (owner == OWN_A);
          timeout_next = !ram_tx_valid;
        end
      end
    endcase
    if (state == IDLE || state_next != state || hs) cnt_next = '0;
    else                                           cnt_next = cnt + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      owner        <= OWN_NONE;
      prio         <= 1'b0;
      cnt          <= '0;
      timeout      <= 1'b0;
      ram_din      <= '0;
      ram_rx_valid <= 1'b0;
      a_rdata      <= '0;
      a_rvalid     <= 1'b0;
      b_rdata      <= '0;
      b_rvalid     <= 1'b0;
    end else begin
      state        <= state_next;
      owner        <= owner_next;
      prio         <= prio_next;
      cnt          <= cnt_next;
      timeout      <= timeout_next;
      ram_rx_valid <= hs;
      a_rvalid     <= 1'b0;
      b_rvalid     <= 1'b0;
      if (hs) ram_din <= frame_sel;
      // Read data outside WAIT_RD has no owner waiting for it and is dropped.
      if (state == WAIT_RD && ram_tx_valid) begin
        if (owner == OWN_A) begin
          a_rdata  <= ram_dout;
          a_rvalid <= 1'b1;
        end else begin
          b_rdata  <= ram_dout;
          b_rvalid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model (lock holder / awaiting-read / idle count).
module tb_ram_port_arbiter;

  localparam int T = 4;

  logic       clk, rst_n;
  logic [9:0] a_frame, b_frame, ram_din;
  logic       a_valid, a_ready, a_rvalid, b_valid, b_ready, b_rvalid;
  logic [7:0] a_rdata, b_rdata, ram_dout;
  logic       ram_rx_valid, ram_tx_valid, timeout;
  logic [1:0] owner;

  int tests = 0;
  int fails = 0;

  ram_port_arbiter #(.TIMEOUT_CYCLES(T), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_frame(a_frame), .a_valid(a_valid), .a_ready(a_ready), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
    .b_frame(b_frame), .b_valid(b_valid), .b_ready(b_ready), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
    .ram_din(ram_din), .ram_rx_valid(ram_rx_valid), .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid),
    .owner(owner), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    a_valid = 0; b_valid = 0; a_frame = 0; b_frame = 0; ram_tx_valid = 0; ram_dout = 0;
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    #1;
  endtask

  task automatic test_reset();
    a_valid = 0; b_valid = 0; a_frame = 0; b_frame = 0; ram_tx_valid = 0; ram_dout = 0;
    rst_n = 0;
    tick();
    tests++; if (owner !== 2'b00) begin fails++; $display("FAIL reset_owner: got %0h want 0", owner); end
    tests++; if ({ram_rx_valid, a_rvalid, b_rvalid, timeout} !== 4'b0) begin fails++; $display("FAIL reset_pulses: got %b want 0000", {ram_rx_valid, a_rvalid, b_rvalid, timeout}); end
    tests++; if ({ram_din, a_rdata, b_rdata} !== 26'd0) begin fails++; $display("FAIL reset_data: got %h want 0", {ram_din, a_rdata, b_rdata}); end
    rst_n = 1;
    #1;
    tests++; if ({a_ready, b_ready} !== 2'b00) begin fails++; $display("FAIL reset_ready_idle: got %b want 00", {a_ready, b_ready}); end
    a_valid = 1;
    #1;
    tests++; if ({a_ready, b_ready} !== 2'b10) begin fails++; $display("FAIL reset_ready_a: got %b want 10", {a_ready, b_ready}); end
    a_valid = 0;
    $display("[TB] test_reset done");
  endtask

  task automatic test_write_pair();
    do_reset();
    a_valid = 1; a_frame = 10'h03A;
    tick();
    tests++; if ({ram_rx_valid, ram_din} !== {1'b1, 10'h03A}) begin fails++; $display("FAIL wr_addr: got %b/%h want 1/03a", ram_rx_valid, ram_din); end
    tests++; if (owner !== 2'b01) begin fails++; $display("FAIL wr_owner_lock: got %0h want 1", owner); end
    a_frame = 10'h15C;
    tick();
    tests++; if ({ram_rx_valid, ram_din} !== {1'b1, 10'h15C}) begin fails++; $display("FAIL wr_data: got %b/%h want 1/15c", ram_rx_valid, ram_din); end
    tests++; if (owner !== 2'b00) begin fails++; $display("FAIL wr_owner_free: got %0h want 0", owner); end
    a_valid = 0;
    tick();
    tests++; if (ram_rx_valid !== 1'b0) begin fails++; $display("FAIL wr_rx_pulse: got %b want 0", ram_rx_valid); end
    a_valid = 1; b_valid = 1;
    #1;
    tests++; if ({a_ready, b_ready} !== 2'b01) begin fails++; $display("FAIL wr_pointer_b: got %b want 01", {a_ready, b_ready}); end
    a_valid = 0; b_valid = 0;
    $display("[TB] test_write_pair done");
  endtask

  task automatic test_read_lock();
    do_reset();
    a_valid = 1; a_frame = 10'h210; b_valid = 1; b_frame = 10'h020;
    #1;
    tests++; if ({a_ready, b_ready} !== 2'b10) begin fails++; $display("FAIL rd_grant: got %b want 10", {a_ready, b_ready}); end
    tick();
    tests++; if ({owner, ram_din} !== {2'b01, 10'h210}) begin fails++; $display("FAIL rd_addr: got %0h/%h want 1/210", owner, ram_din); end
    a_frame = 10'h300;
    #1;
    tests++; if (b_ready !== 1'b0) begin fails++; $display("FAIL rd_b_held1: got %b want 0", b_ready); end
    tick();
    tests++; if ({ram_rx_valid, ram_din} !== {1'b1, 10'h300}) begin fails++; $display("FAIL rd_data_cmd: got %b/%h want 1/300", ram_rx_valid, ram_din); end
    a_valid = 0;
    #1;
    tests++; if ({a_ready, b_ready} !== 2'b00) begin fails++; $display("FAIL rd_wait_ready: got %b want 00", {a_ready, b_ready}); end
    tick();
    ram_tx_valid = 1; ram_dout = 8'hAB;
    tick();
    ram_tx_valid = 0;
    tests++; if ({a_rvalid, a_rdata} !== {1'b1, 8'hAB}) begin fails++; $display("FAIL rd_return: got %b/%h want 1/ab", a_rvalid, a_rdata); end
    tests++; if ({b_rvalid, owner} !== 3'b000) begin fails++; $display("FAIL rd_release: got %b/%0h want 0/0", b_rvalid, owner); end
    #1;
    tests++; if (b_ready !== 1'b1) begin fails++; $display("FAIL rd_b_next: got %b want 1", b_ready); end
    tick();
    tests++; if ({owner, a_rvalid} !== {2'b10, 1'b0}) begin fails++; $display("FAIL rd_b_owner: got %0h/%b want 2/0", owner, a_rvalid); end
    b_frame = 10'h100;
    tick();
    b_valid = 0;
    $display("[TB] test_read_lock done");
  endtask

  task automatic test_round_robin();
    do_reset();
    a_valid = 1; a_frame = 10'h011; b_valid = 1; b_frame = 10'h022;
    #1;
    tests++; if ({a_ready, b_ready} !== 2'b10) begin fails++; $display("FAIL rr_first: got %b want 10", {a_ready, b_ready}); end
    tick();
    a_frame = 10'h111;
    tick();
    a_frame = 10'h033;
    #1;
    tests++; if ({a_ready, b_ready} !== 2'b01) begin fails++; $display("FAIL rr_second: got %b want 01", {a_ready, b_ready}); end
    tick();
    tests++; if ({owner, ram_din} !== {2'b10, 10'h022}) begin fails++; $display("FAIL rr_b_owner: got %0h/%h want 2/022", owner, ram_din); end
    b_frame = 10'h122;
    tick();
    a_valid = 0; b_valid = 0;
    $display("[TB] test_round_robin done");
  endtask

  task automatic test_timeout();
    do_reset();
    b_valid = 1; b_frame = 10'h001;
    tick();
    b_valid = 0;
    tests++; if (owner !== 2'b10) begin fails++; $display("FAIL to_lock: got %0h want 2", owner); end
    for (int i = 1; i < T; i++) begin
      tick();
      tests++; if ({timeout, owner} !== {1'b0, 2'b10}) begin fails++; $display("FAIL to_early%0d: got %b/%0h want 0/2", i, timeout, owner); end
    end
    tick();
    tests++; if ({timeout, owner, ram_rx_valid} !== {1'b1, 2'b00, 1'b0}) begin fails++; $display("FAIL to_fire: got %b/%0h/%b want 1/0/0", timeout, owner, ram_rx_valid); end
    tick();
    tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL to_pulse: got %b want 0", timeout); end
    a_valid = 1; a_frame = 10'h000;
    #1;
    tests++; if (a_ready !== 1'b1) begin fails++; $display("FAIL to_a_grant: got %b want 1", a_ready); end
    tick();
    a_frame = 10'h100;
    tick();
    a_valid = 0;
    $display("[TB] test_timeout done");
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    a_valid = 1; a_frame = 10'h300;
    tick();
    a_valid = 0;
    tests++; if (owner !== 2'b01) begin fails++; $display("FAIL mr_lock: got %0h want 1", owner); end
    #2 rst_n = 0;
    #1;
    tests++; if (owner !== 2'b00) begin fails++; $display("FAIL mr_async: got %0h want 0", owner); end
    tick();
    rst_n = 1;
    ram_tx_valid = 1; ram_dout = 8'h55;
    tick();
    ram_tx_valid = 0;
    tests++; if ({a_rvalid, b_rvalid, owner} !== 4'b0) begin fails++; $display("FAIL mr_drop: got %b%b/%0h want 00/0", a_rvalid, b_rvalid, owner); end
    a_valid = 1;
    #1;
    tests++; if (a_ready !== 1'b1) begin fails++; $display("FAIL mr_idle: got %b want 1", a_ready); end
    a_valid = 0;
    $display("[TB] test_reset_mid_read done");
  endtask

  task automatic test_random();
    int m_owner, m_prio, m_cnt, ncyc, nhs;
    bit m_wait, a_pend, b_pend, ea, eb, hsa, hsb, erx, earv, ebrv, eto, rel;
    logic [9:0] m_din;
    logic [7:0] m_ard, m_brd;
    logic [1:0] cmd;
    do_reset();
    m_owner = 0; m_prio = 1; m_cnt = 0; m_wait = 0; m_din = 0; m_ard = 0; m_brd = 0;
    a_pend = 0; b_pend = 0; nhs = 0; ncyc = 600;
    for (int c = 0; c < ncyc; c++) begin
      if (!a_pend) begin a_pend = ($urandom_range(0, 1) == 1); a_frame = 10'($urandom); end
      if (!b_pend) begin b_pend = ($urandom_range(0, 1) == 1); b_frame = 10'($urandom); end
      a_valid = a_pend; b_valid = b_pend;
      ram_tx_valid = ($urandom_range(0, 3) == 0); ram_dout = 8'($urandom);
      #1;
      ea = (m_owner == 0) ? (a_valid && (!b_valid || m_prio == 1)) : (m_owner == 1 && !m_wait);
      eb = (m_owner == 0) ? (b_valid && (!a_valid || m_prio == 2)) : (m_owner == 2 && !m_wait);
      tests++; if ({a_ready, b_ready} !== {ea, eb}) begin fails++; $display("FAIL rnd_ready c%0d: got %b want %b", c, {a_ready, b_ready}, {ea, eb}); end
      hsa = a_valid && ea; hsb = b_valid && eb;
      @(posedge clk);
      erx = hsa || hsb; earv = 0; ebrv = 0; eto = 0; rel = 0;
      if (erx) begin m_din = hsa ? a_frame : b_frame; nhs++; end
      cmd = m_din[9:8];
      if (m_wait) begin
        if (ram_tx_valid) begin
          if (m_owner == 1) begin earv = 1; m_ard = ram_dout; end
          else              begin ebrv = 1; m_brd = ram_dout; end
          rel = 1;
        end else if (m_cnt == T - 1) begin eto = 1; rel = 1; end
        else m_cnt++;
      end else if (erx) begin
        m_cnt = 0;
        if (cmd == 2'b01) begin
          if (m_owner == 0) m_prio = hsa ? 2 : 1;
          else rel = 1;
        end else begin
          m_owner = hsa ? 1 : 2;
          m_wait  = (cmd == 2'b11);
        end
      end else if (m_owner != 0) begin
        if (m_cnt == T - 1) begin eto = 1; rel = 1; end
        else m_cnt++;
      end
      if (rel) begin m_prio = (m_owner == 1) ? 2 : 1; m_owner = 0; m_wait = 0; m_cnt = 0; end
      if (hsa) a_pend = 0;
      if (hsb) b_pend = 0;
      #1;
      tests++; if ({ram_rx_valid, ram_din} !== {erx, m_din}) begin fails++; $display("FAIL rnd_ram c%0d: got %b/%h want %b/%h", c, ram_rx_valid, ram_din, erx, m_din); end
      tests++; if ({a_rvalid, a_rdata, b_rvalid, b_rdata} !== {earv, m_ard, ebrv, m_brd}) begin fails++; $display("FAIL rnd_rdata c%0d: got %b/%h %b/%h want %b/%h %b/%h", c, a_rvalid, a_rdata, b_rvalid, b_rdata, earv, m_ard, ebrv, m_brd); end
      tests++; if ({owner, timeout} !== {2'(m_owner), eto}) begin fails++; $display("FAIL rnd_owner c%0d: got %0h/%b want %0h/%b", c, owner, timeout, m_owner, eto); end
    end
    a_valid = 0; b_valid = 0; ram_tx_valid = 0;
    $display("[TB] test_random done: %0d cycles, %0d frames accepted", ncyc, nhs);
  endtask

  initial begin
    test_reset();
    test_write_pair();
    test_read_lock();
    test_round_robin();
    test_timeout();
    test_reset_mid_read();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
